// File: rtl/pingpong_write_ctrl_if.sv
// rtl/pingpong_write_ctrl_if.sv - source stream, memory write port and reader-side signals of the ping-pong write controller
//
// Signals:
//   in_data/in_valid/in_ready : source word stream (valid/ready handshake)
//   mem1_we/mem2_we           : write strobes for the two buffers
//   wr_addr/wr_data           : write address/data shared by both buffers
//   rd_done                   : reader finished with the buffer selected by memselect
//   memselect                 : reader mux select (0 = mem1, 1 = mem2)
//   buf_valid                 : reader-side buffer holds a complete, unconsumed frame
//   frame_cnt                 : completed frame count, wraps at 256
// Modports: slave = controller, master = source/reader/memory side.
interface pingpong_write_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              rd_done;
  logic              mem1_we;
  logic              mem2_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              memselect;
  logic              buf_valid;
  logic [7:0]        frame_cnt;

  modport slave (
    input  in_data, in_valid, rd_done,
    output in_ready, mem1_we, mem2_we, wr_addr, wr_data,
           memselect, buf_valid, frame_cnt
  );

  modport master (
    output in_data, in_valid, rd_done,
    input  in_ready, mem1_we, mem2_we, wr_addr, wr_data,
           memselect, buf_valid, frame_cnt
  );
endinterface

// File: rtl/pingpong_write_ctrl.sv
// rtl/pingpong_write_ctrl.sv - write-side controller filling one of two frame buffers while the reader drains the other
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pingpong_write_ctrl_if.slave (stream in, memory write port, reader select/status)
module pingpong_write_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic                 clk,
  input logic                 rst_n,
  pingpong_write_ctrl_if.slave bus
);

  typedef enum logic [0:0] {FILL, WAIT_SWAP} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic              wbuf;       // 0 = writing mem1, 1 = writing mem2
  logic [ADDR_W-1:0] addr;
  logic              sel_pend;   // final strobe of a swapped frame is landing this cycle
  logic              mem1_we_q, mem2_we_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              memselect_q, buf_valid_q;
  logic [7:0]        frame_cnt_q;

  logic in_ready, accept, last_word, swap_fill, swap_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == FILL);
    accept    = in_ready & bus.in_valid;
    last_word = accept && (addr == LAST_ADDR);
    // The reader side is free if it is empty or is being released right now.
    swap_fill = last_word && (!buf_valid_q || bus.rd_done);
    swap_wait = (state == WAIT_SWAP) && bus.rd_done;
    case (state)
      FILL:      if (last_word && !swap_fill) state_nxt = WAIT_SWAP;
      WAIT_SWAP: if (bus.rd_done)             state_nxt = FILL;
      default:                                state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf        <= 1'b0;
      addr        <= '0;
      sel_pend    <= 1'b0;
      mem1_we_q   <= 1'b0;
      mem2_we_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      memselect_q <= 1'b1;
      buf_valid_q <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      mem1_we_q <= accept & ~wbuf;
      mem2_we_q <= accept & wbuf;
      sel_pend  <= swap_fill;

      if (accept) begin
        wr_data_q <= bus.in_data;
        wr_addr_q <= addr;
        addr      <= last_word ? '0 : addr + 1'b1;
      end

      if (swap_fill) wbuf <= ~wbuf;

      if (sel_pend) begin
        // wbuf already toggled, so the completed buffer is its complement.
        memselect_q <= ~wbuf;
        buf_valid_q <= 1'b1;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end else if (swap_wait) begin
        wbuf        <= ~wbuf;
        memselect_q <= wbuf;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end else if (bus.rd_done && buf_valid_q && !swap_fill) begin
        buf_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem1_we   = mem1_we_q;
  assign bus.mem2_we   = mem2_we_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.memselect = memselect_q;
  assign bus.buf_valid = buf_valid_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pingpong_write_ctrl.sv
// tb/tb_pingpong_write_ctrl.sv - self-checking bench for pingpong_write_ctrl (DEPTH = 4)
module tb_pingpong_write_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pingpong_write_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  pingpong_write_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected memory writes.
  typedef struct {
    logic              b;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;
  wr_t sbq[$];

  // Reference model.
  logic              m_fill, m_wbuf, m_pend, m_sel, m_bv;
  logic [ADDR_W-1:0] m_addr, m_wa;
  logic [DATA_W-1:0] m_wd;
  logic              m_we1, m_we2;
  logic [7:0]        m_fc;
  int                m_frames;

  task automatic model_reset();
    m_fill = 1; m_wbuf = 0; m_pend = 0; m_sel = 1; m_bv = 0;
    m_addr = 0; m_wa = 0; m_wd = 0; m_we1 = 0; m_we2 = 0; m_fc = 0;
    m_frames = 0;
    sbq.delete();
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic acc, last, rd, freed;
    wr_t w;
    rd    = bus.rd_done;
    acc   = m_fill && bus.in_valid;
    last  = acc && (m_addr == ADDR_W'(DEPTH - 1));
    freed = !m_bv || rd;
    m_we1 = acc && !m_wbuf;
    m_we2 = acc && m_wbuf;
    if (acc) begin
      w.b = m_wbuf; w.a = m_addr; w.d = bus.in_data;
      sbq.push_back(w);
      m_wa = m_addr; m_wd = bus.in_data;
    end
    if (m_pend) begin
      // frame completed on the previous edge becomes visible to the reader
      m_sel = ~m_wbuf; m_bv = 1; m_fc++; m_frames++; m_pend = 0;
    end else if (!m_fill) begin
      if (rd) begin
        m_sel = m_wbuf; m_wbuf = ~m_wbuf; m_fc++; m_frames++; m_fill = 1;
      end
    end else if (rd && m_bv && !last) begin
      m_bv = 0;
    end
    if (last) begin
      m_addr = 0;
      if (freed) begin m_wbuf = ~m_wbuf; m_pend = 1; end
      else m_fill = 0;
    end else if (acc) begin
      m_addr = m_addr + 1'b1;
    end
  endtask

  task automatic check_all();
    wr_t w;
    logic any;
    chk("in_ready", bus.in_ready, m_fill);
    chk("mem1_we", bus.mem1_we, m_we1);
    chk("mem2_we", bus.mem2_we, m_we2);
    chk("wr_addr", bus.wr_addr, m_wa);
    chk("wr_data", bus.wr_data, m_wd);
    chk("memselect", bus.memselect, m_sel);
    chk("buf_valid", bus.buf_valid, m_bv);
    chk("frame_cnt", bus.frame_cnt, m_fc);
    chk("we_exclusive", bus.mem1_we & bus.mem2_we, 1'b0);
    any = bus.mem1_we | bus.mem2_we;
    if (any === 1'b1) begin
      chk("sb_has_entry", sbq.size() != 0, 1'b1);
      if (sbq.size() != 0) begin
        w = sbq.pop_front();
        chk("sb_buf", bus.mem2_we, w.b);
        chk("sb_addr", bus.wr_addr, w.a);
        chk("sb_data", bus.wr_data, w.d);
      end
    end
  endtask

  // One clock: drive inputs now (negedge), update model at posedge, check at next negedge.
  task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic rd);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.rd_done  = rd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic              rd;
    logic              e_rdy, e_we1, e_we2;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic              e_sel, e_bv;
    logic [7:0]        e_fc;
  } vec_t;
  vec_t vecs[6];

  int target;
  int bound;
  logic [DATA_W-1:0] wcnt;

  initial begin
    //                v  d         rd rdy we1 we2 addr data      sel bv fc
    vecs[0] = '{1'b1, 16'hA000, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 16'hA000, 1'b1, 1'b0, 8'd0};
    vecs[1] = '{1'b1, 16'hA001, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 16'hA001, 1'b1, 1'b0, 8'd0};
    vecs[2] = '{1'b1, 16'hA002, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 16'hA002, 1'b1, 1'b0, 8'd0};
    vecs[3] = '{1'b1, 16'hA003, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 16'hA003, 1'b1, 1'b0, 8'd0};
    vecs[4] = '{1'b1, 16'hB000, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 16'hB000, 1'b0, 1'b1, 8'd1};
    vecs[5] = '{1'b0, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'hB000, 1'b0, 1'b1, 8'd1};

    // Reset held with in_valid high.
    bus.in_valid = 1; bus.in_data = 16'h1234; bus.rd_done = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1;

    // Two words, then asynchronous reset mid-cycle.
    cyc(1, 16'h7700, 0);
    cyc(1, 16'h7701, 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1;

    // First frame, table-driven.
    for (int i = 0; i < 6; i++) begin
      cyc(vecs[i].v, vecs[i].d, vecs[i].rd);
      chk($sformatf("vec%0d_ready", i), bus.in_ready, vecs[i].e_rdy);
      chk($sformatf("vec%0d_we1", i), bus.mem1_we, vecs[i].e_we1);
      chk($sformatf("vec%0d_we2", i), bus.mem2_we, vecs[i].e_we2);
      chk($sformatf("vec%0d_addr", i), bus.wr_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_data", i), bus.wr_data, vecs[i].e_data);
      chk($sformatf("vec%0d_sel", i), bus.memselect, vecs[i].e_sel);
      chk($sformatf("vec%0d_bv", i), bus.buf_valid, vecs[i].e_bv);
      chk($sformatf("vec%0d_fc", i), bus.frame_cnt, vecs[i].e_fc);
    end

    // Back-pressure: frame 2 completes while frame 1 is unconsumed.
    cyc(1, 16'hB001, 0);
    cyc(1, 16'hB002, 0);
    cyc(1, 16'hB003, 0);
    chk("bp_ready_low", bus.in_ready, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1, 16'($urandom), 0);
    chk("bp_no_strobe", bus.mem1_we | bus.mem2_we, 1'b0);
    cyc(1, 16'hEEEE, 1);
    chk("bp_sel", bus.memselect, 1'b1);
    chk("bp_fc", bus.frame_cnt, 8'd2);
    chk("bp_ready_back", bus.in_ready, 1'b1);
    chk("bp_bv", bus.buf_valid, 1'b1);

    // Simultaneous rd_done with the final word.
    cyc(1, 16'hC000, 0);
    cyc(1, 16'hC001, 0);
    cyc(1, 16'hC002, 0);
    cyc(1, 16'hC003, 1);
    chk("sim_ready", bus.in_ready, 1'b1);
    cyc(0, 16'h0000, 0);
    chk("sim_sel", bus.memselect, 1'b0);
    chk("sim_bv", bus.buf_valid, 1'b1);
    chk("sim_fc", bus.frame_cnt, 8'd3);

    // Idle release, spurious rd_done, then immediate swap.
    cyc(0, 16'h0000, 1);
    chk("idle_bv_clear", bus.buf_valid, 1'b0);
    cyc(0, 16'h0000, 1);
    chk("spurious_bv", bus.buf_valid, 1'b0);
    chk("spurious_fc", bus.frame_cnt, 8'd3);
    for (int i = 0; i < DEPTH; i++) cyc(1, 16'hD000 + 16'(i), 0);
    chk("idle_ready", bus.in_ready, 1'b1);
    cyc(0, 16'h0000, 0);
    chk("idle_bv_set", bus.buf_valid, 1'b1);
    chk("idle_sel", bus.memselect, 1'b1);
    chk("idle_fc", bus.frame_cnt, 8'd4);

    // Random gaps and random reader releases across 260 frames.
    target = m_frames + 260;
    wcnt = 0;
    bound = 0;
    while (m_frames < target && bound < 20000) begin
      if (m_fill && bus.in_valid) wcnt++;
      cyc($urandom_range(0, 3) != 0, m_fill ? wcnt : 16'($urandom), $urandom_range(0, 3) == 0);
      bound++;
    end
    chk("rand_bound", bound < 20000, 1'b1);
    chk("rand_fc_wrap", bus.frame_cnt, 8'(m_frames));
    cyc(0, 16'h0000, 0);
    cyc(0, 16'h0000, 0);
    chk("sb_drain", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
